// File: rtl/serial_shifter.sv
// serial_shifter: iterative 32-bit shifter that moves up to SHIFT_PER_CYCLE bits
// per busy cycle, using a valid/ready request and a held response.
module serial_shifter #(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] A,
    input  logic [4:0]  B,
    input  logic [1:0]  Shiftop,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] Result
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [4:0] STEP = 5'(SHIFT_PER_CYCLE);

    logic [1:0]  state;
    logic [1:0]  op;
    logic [4:0]  count;
    logic [4:0]  step;
    logic        sign;
    logic [63:0] ext;
    logic [31:0] shifted;

    assign req_ready  = state == IDLE;
    assign resp_valid = state == DONE;

    // Right shifts go through a 64-bit extension so the fill comes from the latched sign.
    always_comb begin
        step    = count < STEP ? count : STEP;
        ext     = {{32{op[0] & sign}}, Result} >> step;
        shifted = op[1] ? ext[31:0] : Result << step;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            Result <= '0;
            count  <= '0;
            op     <= '0;
            sign   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op    <= Shiftop;
                    sign  <= A[31];
                    count <= B;
                    if (Shiftop == 2'b01) begin
                        Result <= '0;
                        state  <= DONE;
                    end else begin
                        Result <= A;
                        state  <= B == 5'd0 ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    Result <= shifted;
                    count  <= count - step;
                    if (count == step) state <= DONE;
                end
                DONE: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_shifter.sv
// tb_serial_shifter: directed checks of serial_shifter with SHIFT_PER_CYCLE 1 and 4.
module tb_serial_shifter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic [31:0] A = '0;
    logic [4:0]  B = '0;
    logic [1:0]  Shiftop = '0;
    logic        sel = 1'b0;
    logic        rdy1, rdy4, vld1, vld4;
    logic [31:0] res1, res4;
    logic        req_ready, resp_valid;
    logic [31:0] Result;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    serial_shifter #(.SHIFT_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy1),
        .A(A), .B(B), .Shiftop(Shiftop), .resp_valid(vld1),
        .resp_ready(resp_ready & ~sel), .Result(res1)
    );
    serial_shifter #(.SHIFT_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy4),
        .A(A), .B(B), .Shiftop(Shiftop), .resp_valid(vld4),
        .resp_ready(resp_ready & sel), .Result(res4)
    );

    assign req_ready  = sel ? rdy4 : rdy1;
    assign resp_valid = sel ? vld4 : vld1;
    assign Result     = sel ? res4 : res1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request, then scrambles operands so only the accept-edge sample matters.
    task automatic start_op(input string tag, input logic [31:0] a, input logic [4:0] b, input logic [1:0] op);
        @(negedge clk);
        A = a; B = b; Shiftop = op; req_valid = 1'b1;
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0; A = ~a; B = ~b; Shiftop = ~op;
    endtask

    task automatic wait_resp(input string tag, input int lat, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        while (!resp_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_result"}, Result, exp);
    endtask

    task automatic release_resp(input string tag, input logic [31:0] exp);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_idle_hold"}, Result, exp);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [4:0] b,
                         input logic [1:0] op, input int lat, input logic [31:0] exp);
        start_op(tag, a, b, op);
        wait_resp(tag, lat, exp);
        release_resp(tag, exp);
    endtask

    initial begin
        #1;
        check("reset_ready", 32'(rdy1), 32'd1);
        check("reset_valid", 32'(vld1), 32'd0);
        check("reset_result", res1, 32'h0);
        @(negedge clk) rst = 1'b1;

        do_op("sra4", 32'h8000_0001, 5'd4, 2'b11, 4, 32'hF800_0000);
        do_op("srl4", 32'h8000_0001, 5'd4, 2'b10, 4, 32'h0800_0000);
        do_op("sll4", 32'h8000_0001, 5'd4, 2'b00, 4, 32'h0000_0010);
        do_op("b0", 32'h1234_5678, 5'd0, 2'b00, 0, 32'h1234_5678);
        do_op("op01", 32'h1234_5678, 5'd7, 2'b01, 0, 32'h0000_0000);
        do_op("sra31", 32'h8000_0000, 5'd31, 2'b11, 31, 32'hFFFF_FFFF);
        do_op("srl31", 32'h8000_0000, 5'd31, 2'b10, 31, 32'h0000_0001);
        do_op("srl8", 32'h1234_5678, 5'd8, 2'b10, 8, 32'h0012_3456);
        do_op("sll1", 32'hFFFF_FFFF, 5'd1, 2'b00, 1, 32'hFFFF_FFFE);
        do_op("sra_pos", 32'h7000_0000, 5'd4, 2'b11, 4, 32'h0700_0000);

        // Response stall with a competing request pending.
        start_op("stall", 32'h8000_0001, 5'd4, 2'b00);
        wait_resp("stall", 4, 32'h0000_0010);
        A = 32'hDEAD_BEEF; B = 5'd2; Shiftop = 2'b00; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_result", Result, 32'h0000_0010);
        end
        req_valid = 1'b0;
        release_resp("stall", 32'h0000_0010);

        // Asynchronous reset in the middle of a long operation.
        start_op("abort", 32'hFFFF_FFFF, 5'd20, 2'b00);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_valid", 32'(resp_valid), 32'd0);
        check("abort_result", Result, 32'h0);
        @(negedge clk) rst = 1'b1;
        repeat (25) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        do_op("post_reset", 32'h0000_0001, 5'd3, 2'b00, 3, 32'h0000_0008);

        sel = 1'b1;
        do_op("w4_sra31", 32'h8000_0000, 5'd31, 2'b11, 8, 32'hFFFF_FFFF);
        do_op("w4_sra5", 32'h8000_0000, 5'd5, 2'b11, 2, 32'hFC00_0000);
        do_op("w4_sll3", 32'h0000_0001, 5'd3, 2'b00, 1, 32'h0000_0008);
        do_op("w4_srl16", 32'hABCD_1234, 5'd16, 2'b10, 4, 32'h0000_ABCD);
        do_op("w4_b0", 32'hCAFE_F00D, 5'd0, 2'b11, 0, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
